// File: rtl/p2s_serializer_mc_pkg.sv
// p2s_pkg: shared types and helpers for the multi-lane P2S serializer.
// Contents: FSM state enum, frame width derivation, default fill word.
// Build option: P2S_PARITY_EN appends an even-parity bit to every frame.
package p2s_pkg;

    typedef enum logic {
        SYNC   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

    localparam logic [7:0] DEFAULT_IDLE_WORD = 8'hBC;

    // Serial bits per frame: payload, plus one parity bit when enabled.
    function automatic int frame_w(input int data_w);
`ifdef P2S_PARITY_EN
        return data_w + 1;
`else
        return data_w;
`endif
    endfunction

endpackage

// File: rtl/p2s_serializer_mc_if.sv
// p2s_serializer_mc_if: parallel input handshake and serial lane outputs.
// Signals:
//   in_data     NUM_CH*DATA_W  lane k word at [k*DATA_W +: DATA_W]
//   in_valid    NUM_CH         per-lane word valid
//   in_ready    NUM_CH         per-lane ready (transfer on valid & ready)
//   ser_out     NUM_CH         serial bit per lane, MSB first
//   frame_start 1              high during bit 0 of every frame
//   idle_frame  NUM_CH         lane is sending the fill word this frame
//   sync_done   1              serializer has left the sync phase
// Modports: master = data source / lane consumer, slave = serializer.
interface p2s_serializer_mc_if #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 8
);
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic [NUM_CH-1:0]        in_valid;
    logic [NUM_CH-1:0]        in_ready;
    logic [NUM_CH-1:0]        ser_out;
    logic                     frame_start;
    logic [NUM_CH-1:0]        idle_frame;
    logic                     sync_done;

    modport master (
        output in_data, in_valid,
        input  in_ready, ser_out, frame_start, idle_frame, sync_done
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, ser_out, frame_start, idle_frame, sync_done
    );
endinterface

// File: rtl/p2s_serializer_mc_lane.sv
// p2s_lane: one serial lane, a 1-entry holding buffer feeding a shift register.
// Ports:
//   clk, reset   clock and asynchronous active-high reset
//   load         frame boundary: shift register reloads this cycle
//   active_d     next-cycle FSM state is ACTIVE
//   in_data/in_valid/in_ready  word handshake for this lane
//   ser_out      MSB of the shift register
//   idle_frame   current frame carries the fill word
// Build option: P2S_PARITY_EN appends ^word as the last frame bit.
module p2s_lane
    import p2s_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter logic [DATA_W-1:0] IDLE_WORD = DATA_W'(DEFAULT_IDLE_WORD),
    parameter int                FRAME_W   = frame_w(DATA_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              active_d,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              ser_out,
    output logic              idle_frame
);

    function automatic logic [FRAME_W-1:0] to_frame(input logic [DATA_W-1:0] w);
`ifdef P2S_PARITY_EN
        return {w, ^w};
`else
        return w;
`endif
    endfunction

    logic [DATA_W-1:0]  hb_q, hb_d;
    logic               hb_full_q, hb_full_d;
    logic [FRAME_W-1:0] sr_q, sr_d;
    logic               idle_frame_q, idle_frame_d;
    logic               in_ready_q, in_ready_d;
    logic               accept;

    assign accept = in_valid && in_ready_q;

    always_comb begin
        hb_d         = hb_q;
        hb_full_d    = hb_full_q;
        sr_d         = sr_q;
        idle_frame_d = idle_frame_q;

        if (load) begin
            if (hb_full_q) begin
                sr_d         = to_frame(hb_q);
                idle_frame_d = 1'b0;
                hb_full_d    = 1'b0;
            end else begin
                sr_d         = to_frame(IDLE_WORD);
                idle_frame_d = 1'b1;
            end
        end else begin
            sr_d = sr_q << 1;
        end

        // Applied after the drain so a same-edge accept refills hb.
        if (accept) begin
            hb_d      = in_data;
            hb_full_d = 1'b1;
        end

        // Built from next-state values so ready never exposes a full buffer.
        in_ready_d = active_d && !hb_full_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hb_q         <= '0;
            hb_full_q    <= 1'b0;
            sr_q         <= '0;
            idle_frame_q <= 1'b0;
            in_ready_q   <= 1'b0;
        end else begin
            hb_q         <= hb_d;
            hb_full_q    <= hb_full_d;
            sr_q         <= sr_d;
            idle_frame_q <= idle_frame_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign ser_out    = sr_q[FRAME_W-1];
    assign idle_frame = idle_frame_q;
    assign in_ready   = in_ready_q;

endmodule

// File: rtl/p2s_serializer_mc.sv
// p2s_serializer_mc: NUM_CH-lane frame-aligned parallel-to-serial converter.
// Ports:
//   clk    single clock, posedge
//   reset  asynchronous active-high reset
//   bus    p2s_serializer_mc_if.slave (handshake in, serial lanes out)
// Build option: P2S_PARITY_EN makes frames DATA_W+1 bits with even parity.
//
// state  | meaning
// SYNC   | sending SYNC_FRAMES fill frames, inputs ignored
// ACTIVE | accepting words; held until reset
module p2s_serializer_mc
    import p2s_pkg::*;
#(
    parameter int                NUM_CH      = 2,
    parameter int                DATA_W      = 8,
    parameter logic [DATA_W-1:0] IDLE_WORD   = DATA_W'(DEFAULT_IDLE_WORD),
    parameter int                SYNC_FRAMES = 4
) (
    input logic                clk,
    input logic                reset,
    p2s_serializer_mc_if.slave bus
);

    localparam int FRAME_W = frame_w(DATA_W);
    localparam int CNT_W   = $clog2(FRAME_W);
    localparam int SYNC_W  = (SYNC_FRAMES > 1) ? $clog2(SYNC_FRAMES) : 1;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SYNC_W-1:0] sync_cnt_q, sync_cnt_d;
    logic              started_q, started_d;
    logic              frame_start_q, frame_start_d;
    logic              sync_done_q, sync_done_d;
    logic              boundary;
    logic              load;

    logic [NUM_CH-1:0] ready_vec;
    logic [NUM_CH-1:0] ser_vec;
    logic [NUM_CH-1:0] idle_vec;

    always_comb begin
        // The first edge out of reset loads the fill word without advancing cnt.
        started_d  = 1'b1;
        boundary   = started_q && (cnt_q == CNT_W'(FRAME_W - 1));
        load       = !started_q || boundary;
        cnt_d      = load ? '0 : cnt_q + CNT_W'(1);
        state_d    = state_q;
        sync_cnt_d = sync_cnt_q;

        if (state_q == SYNC && boundary) begin
            if (sync_cnt_q == SYNC_W'(SYNC_FRAMES - 1)) begin
                state_d = ACTIVE;
            end else begin
                sync_cnt_d = sync_cnt_q + SYNC_W'(1);
            end
        end

        frame_start_d = load;
        sync_done_d   = (state_d == ACTIVE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= SYNC;
            cnt_q         <= '0;
            sync_cnt_q    <= '0;
            started_q     <= 1'b0;
            frame_start_q <= 1'b0;
            sync_done_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            sync_cnt_q    <= sync_cnt_d;
            started_q     <= started_d;
            frame_start_q <= frame_start_d;
            sync_done_q   <= sync_done_d;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
        p2s_lane #(
            .DATA_W   (DATA_W),
            .IDLE_WORD(IDLE_WORD),
            .FRAME_W  (FRAME_W)
        ) u_lane (
            .clk       (clk),
            .reset     (reset),
            .load      (load),
            .active_d  (state_d == ACTIVE),
            .in_data   (bus.in_data[k*DATA_W +: DATA_W]),
            .in_valid  (bus.in_valid[k]),
            .in_ready  (ready_vec[k]),
            .ser_out   (ser_vec[k]),
            .idle_frame(idle_vec[k])
        );
    end

    assign bus.in_ready    = ready_vec;
    assign bus.ser_out     = ser_vec;
    assign bus.idle_frame  = idle_vec;
    assign bus.frame_start = frame_start_q;
    assign bus.sync_done   = sync_done_q;

endmodule
